// File: rtl/usb_uc_loader.sv
// Microcode loader: parses a framed byte stream into 16-bit words and writes them
// to the microcode RAM at sequential wrapping addresses, with an optional checksum.
module usb_uc_loader #(
    parameter int ADDR_W  = 8,
    parameter bit CSUM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] uc_addr,
    output logic [15:0]       uc_data,
    output logic              uc_we,
    output logic              busy,
    output logic              done,
    output logic              ok
);

    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_CNT,
        W_LO,
        W_HI,
        CS_LO,
        CS_HI,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [15:0]       sum_q, sum_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        cs_lo_q, cs_lo_d;
    logic [ADDR_W-1:0] uc_addr_q, uc_addr_d;
    logic [15:0]       uc_data_q, uc_data_d;
    logic              uc_we_q, uc_we_d;
    logic              ok_q, ok_d;
    logic              accept;
    logic [15:0]       word;

    assign in_ready = (state_q != FIN);
    assign busy     = (state_q != HDR_ADDR);
    assign done     = (state_q == FIN);
    assign uc_addr  = uc_addr_q;
    assign uc_data  = uc_data_q;
    assign uc_we    = uc_we_q;
    assign ok       = ok_q;

    assign accept = in_valid & in_ready;
    assign word   = {in_data, lo_q};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        lo_d      = lo_q;
        cs_lo_d   = cs_lo_q;
        uc_addr_d = uc_addr_q;
        uc_data_d = uc_data_q;
        uc_we_d   = 1'b0;
        ok_d      = ok_q;
        case (state_q)
            HDR_ADDR: if (accept) begin
                ptr_d   = ADDR_W'(in_data);
                state_d = HDR_CNT;
            end
            HDR_CNT: if (accept) begin
                // A count byte of zero stands for a full 256-word frame.
                cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                sum_d   = 16'd0;
                state_d = W_LO;
            end
            W_LO: if (accept) begin
                lo_d    = in_data;
                state_d = W_HI;
            end
            W_HI: if (accept) begin
                uc_data_d = word;
                uc_addr_d = ptr_q;
                uc_we_d   = 1'b1;
                ptr_d     = ptr_q + ADDR_W'(1);
                cnt_d     = cnt_q - 9'd1;
                sum_d     = sum_q + word;
                if (cnt_q == 9'd1) begin
                    if (CSUM_EN) begin
                        state_d = CS_LO;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = FIN;
                    end
                end else begin
                    state_d = W_LO;
                end
            end
            CS_LO: if (accept) begin
                cs_lo_d = in_data;
                state_d = CS_HI;
            end
            CS_HI: if (accept) begin
                ok_d    = ({in_data, cs_lo_q} == sum_q);
                state_d = FIN;
            end
            FIN:     state_d = HDR_ADDR;
            default: state_d = HDR_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HDR_ADDR;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            lo_q      <= '0;
            cs_lo_q   <= '0;
            uc_addr_q <= '0;
            uc_data_q <= '0;
            uc_we_q   <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            lo_q      <= lo_d;
            cs_lo_q   <= cs_lo_d;
            uc_addr_q <= uc_addr_d;
            uc_data_q <= uc_data_d;
            uc_we_q   <= uc_we_d;
            ok_q      <= ok_d;
        end
    end

endmodule

// File: tb/tb_usb_uc_loader.sv
// Directed bench for usb_uc_loader: one checksummed instance and one without checksum.
module tb_usb_uc_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0, in_data0 = 8'd0;
    logic        in_valid = 1'b0, in_valid0 = 1'b0;
    logic        in_ready, in_ready0;
    logic [7:0]  uc_addr, uc_addr0;
    logic [15:0] uc_data, uc_data0;
    logic        uc_we, uc_we0, busy, busy0, done, done0, ok, ok0;

    usb_uc_loader #(.ADDR_W(8), .CSUM_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .uc_addr(uc_addr), .uc_data(uc_data), .uc_we(uc_we), .busy(busy), .done(done), .ok(ok));

    usb_uc_loader #(.ADDR_W(8), .CSUM_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .uc_addr(uc_addr0), .uc_data(uc_data0), .uc_we(uc_we0), .busy(busy0), .done(done0), .ok(ok0));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    logic        dok_q[$];
    int          dc_q[$];

    always @(negedge clk) begin
        if (uc_we) begin
            wa_q.push_back(uc_addr);
            wd_q.push_back(uc_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            dok_q.push_back(ok);
            dc_q.push_back(cyc);
        end
    end

    int          w0_n = 0, w0_cyc = 0, nr0_n = 0, nr0_cyc = 0;
    logic [7:0]  w0_a = 8'd0;
    logic [15:0] w0_d = 16'd0;
    logic        done0_at_we = 1'b0, ok0_at_we = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (uc_we0) begin
                w0_n++;
                w0_cyc      = cyc;
                w0_a        = uc_addr0;
                w0_d        = uc_data0;
                done0_at_we = done0;
                ok0_at_we   = ok0;
            end
            if (!in_ready0) begin
                nr0_n++;
                nr0_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send(input bit which, input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        if (which) begin in_data0 = b; in_valid0 = 1'b1; end
        else begin in_data = b; in_valid = 1'b1; end
        t = 0;
        while (!(which ? in_ready0 : in_ready) && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("ready_wait", 32'(t), 32'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
    endtask

    function automatic int gap(input int gmax);
        return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    endfunction

    task automatic frame(input logic [7:0] base, input logic [7:0] nb, input logic [15:0] w[$],
                         input logic [15:0] cs, input int gmax);
        send(0, base, gap(gmax));
        send(0, nb, gap(gmax));
        foreach (w[i]) begin
            send(0, w[i][7:0], gap(gmax));
            send(0, w[i][15:8], gap(gmax));
        end
        send(0, cs[7:0], gap(gmax));
        send(0, cs[15:8], gap(gmax));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clearq();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dok_q.delete(); dc_q.delete();
    endtask

    task automatic check_writes(input string tag, input logic [7:0] base, input logic [15:0] w[$],
                                input bit exact);
        logic [7:0] a;
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(w.size()));
        if (wa_q.size() == w.size()) begin
            foreach (w[i]) begin
                a = base + 8'(i);
                chk($sformatf("%s_a%0d", tag, i), 32'(wa_q[i]), 32'(a));
                chk($sformatf("%s_d%0d", tag, i), 32'(wd_q[i]), 32'(w[i]));
                if (exact && i > 0) chk($sformatf("%s_sp%0d", tag, i), 32'(wc_q[i] - wc_q[i-1]), 32'd2);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic exp_ok);
        chk({tag, "_ndone"}, 32'(dok_q.size()), 32'd1);
        if (dok_q.size() == 1) chk({tag, "_ok"}, 32'(dok_q[0]), 32'(exp_ok));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [15:0] wa[$];
    logic [15:0] wb[$];
    logic [15:0] wc[$];
    int          nbefore;

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_we", 32'(uc_we), 32'd0);
        chk("rst_addr", 32'(uc_addr), 32'd0);
        chk("rst_data", 32'(uc_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Basic frame, no gaps
        wa = '{16'h1234, 16'hABCD};
        clearq();
        frame(8'h10, 8'd2, wa, 16'hBE01, 0);
        settle();
        check_writes("basic", 8'h10, wa, 1'b1);
        check_status("basic", 1'b1);
        if (dc_q.size() == 1 && wc_q.size() == 2) chk("basic_done_lat", 32'(dc_q[0] - wc_q[1]), 32'd2);

        // Bad checksum, then a good frame
        clearq();
        frame(8'h10, 8'd2, wa, 16'h0000, 0);
        settle();
        check_writes("badcs", 8'h10, wa, 1'b1);
        check_status("badcs", 1'b0);
        clearq();
        frame(8'h10, 8'd2, wa, 16'hBE01, 0);
        settle();
        check_status("goodafter", 1'b1);

        // Address wrap
        wb = '{16'h0001, 16'h0002, 16'h0003};
        clearq();
        frame(8'hFF, 8'd3, wb, 16'h0006, 0);
        settle();
        check_writes("wrap", 8'hFF, wb, 1'b1);
        check_status("wrap", 1'b1);

        // Full 256-word frame
        wc.delete();
        for (int i = 0; i < 256; i++) wc.push_back(16'(i));
        clearq();
        frame(8'h00, 8'h00, wc, 16'h7F80, 0);
        settle();
        check_writes("full", 8'h00, wc, 1'b1);
        check_status("full", 1'b1);

        // Random in_valid gaps
        clearq();
        frame(8'h10, 8'd2, wa, 16'hBE01, 5);
        settle();
        check_writes("gaps", 8'h10, wa, 1'b0);
        check_status("gaps", 1'b1);

        // Reset after the lo byte of word 1
        clearq();
        send(0, 8'h10, gap(5));
        send(0, 8'h02, gap(5));
        send(0, 8'h34, gap(5));
        send(0, 8'h12, gap(5));
        send(0, 8'hCD, gap(5));
        rst = 1'b0;
        #1;
        chk("mrst_we", 32'(uc_we), 32'd0);
        chk("mrst_addr", 32'(uc_addr), 32'd0);
        chk("mrst_data", 32'(uc_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ok", 32'(ok), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        nbefore = wa_q.size();
        chk("mrst_nwr_before", 32'(nbefore), 32'd1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        settle();
        chk("mrst_nwr_after", 32'(wa_q.size()), 32'(nbefore));
        clearq();
        wb = '{16'h0102};
        frame(8'h40, 8'd1, wb, 16'h0102, 0);
        settle();
        check_writes("postrst", 8'h40, wb, 1'b1);
        check_status("postrst", 1'b1);

        // No-checksum instance
        nr0_n = 0;
        send(1, 8'h20, 0);
        send(1, 8'h01, 0);
        send(1, 8'h5A, 0);
        send(1, 8'h5A, 0);
        settle();
        chk("nocs_nwr", 32'(w0_n), 32'd1);
        chk("nocs_addr", 32'(w0_a), 32'h20);
        chk("nocs_data", 32'(w0_d), 32'h5A5A);
        chk("nocs_done", 32'(done0_at_we), 32'd1);
        chk("nocs_ok", 32'(ok0_at_we), 32'd1);
        chk("nocs_nready_n", 32'(nr0_n), 32'd1);
        chk("nocs_nready_cyc", 32'(nr0_cyc), 32'(w0_cyc));
        chk("nocs_busy", 32'(busy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
